// File: rtl/stopwatch_pkg.sv
// Shared constants and types for the stopwatch display blocks:
// active-low segment patterns, digit index type and BCD nibble positions.
package stopwatch_pkg;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef logic [1:0] digit_idx_t;

  localparam digit_idx_t SEC_U = 2'd0;
  localparam digit_idx_t SEC_T = 2'd1;
  localparam digit_idx_t MIN_U = 2'd2;
  localparam digit_idx_t MIN_T = 2'd3;

  typedef struct packed {
    logic [15:0] time_bcd;
    logic        running;
    logic        limit;
    logic        lzb;
  } snap_t;

  function automatic logic [3:0] get_nibble(input logic [15:0] value, input digit_idx_t idx);
    logic [3:0] nib;
    case (idx)
      SEC_U:   nib = value[3:0];
      SEC_T:   nib = value[7:4];
      MIN_U:   nib = value[11:8];
      MIN_T:   nib = value[15:12];
      default: nib = 4'h0;
    endcase
    return nib;
  endfunction

endpackage

// File: rtl/stopwatch_display_scan_if.sv
// Display-side bundle: BCD time and status in, multiplexed 7-segment drive out.
interface stopwatch_display_scan_if;
  logic [15:0] TIME_BCD;
  logic        RUNNING;
  logic        LIMIT;
  logic        LZB;
  logic [3:0]  AN;
  logic [6:0]  SEG;
  logic        DP;

  modport master (
    output TIME_BCD, RUNNING, LIMIT, LZB,
    input  AN, SEG, DP
  );

  modport slave (
    input  TIME_BCD, RUNNING, LIMIT, LZB,
    output AN, SEG, DP
  );
endinterface

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-low 7-segment pattern; non-BCD codes show a dash.
module bcd_to_seg7
  import stopwatch_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Digit lookup
  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/stopwatch_display_scan.sv
// Multiplexed 4-digit MM:SS display driver with per-frame snapshot, anti-ghost
// guard, leading-zero blanking, colon and limit blink.
module stopwatch_display_scan
  import stopwatch_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int GUARD        = 2,
  parameter int BLINK_FRAMES = 64
) (
  input logic                     clk_in,
  input logic                     RESET,
  stopwatch_display_scan_if.slave bus
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_CNT = CNT_W'(GUARD);
  localparam logic [FRM_W-1:0] FRM_LAST  = FRM_W'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0] slot_cnt_r;
  digit_idx_t       idx_r;
  logic [FRM_W-1:0] frame_cnt_r;
  logic             phase_r;
  snap_t            snap_r;
  logic [3:0]       an_r;
  logic [6:0]       seg_r;
  logic             dp_r;

  logic             slot_last_s;
  logic             frame_wrap_s;
  logic [3:0]       digit_s;
  logic [6:0]       seg_s;
  logic             lzb_blank_s;
  logic             limit_blank_s;
  logic             an_en_s;
  logic [3:0]       an_next_s;
  logic             dp_next_s;

  assign slot_last_s  = (slot_cnt_r == SLOT_LAST);
  assign frame_wrap_s = slot_last_s && (idx_r == MIN_T);
  assign digit_s      = get_nibble(snap_r.time_bcd, idx_r);

  bcd_to_seg7 u_dec (
    .bcd (digit_s),
    .seg (seg_s)
  );

  // Next-cycle anode and colon decisions from the frozen frame snapshot
  always_comb begin
    lzb_blank_s   = (idx_r == MIN_T) && snap_r.lzb && (digit_s == 4'h0);
    limit_blank_s = snap_r.limit && !phase_r;
    an_en_s       = (slot_cnt_r >= GUARD_CNT) && !limit_blank_s && !lzb_blank_s;
    an_next_s     = 4'b1111;
    if (an_en_s) begin
      an_next_s[idx_r] = 1'b0;
    end else begin
      an_next_s = 4'b1111;
    end
    // Colon is steady while running and follows the blink phase when paused
    if ((idx_r == MIN_U) && an_en_s && (snap_r.running || phase_r)) begin
      dp_next_s = 1'b0;
    end else begin
      dp_next_s = 1'b1;
    end
  end

  // Slot counter and digit index
  always_ff @(posedge clk_in or posedge RESET) begin
    if (RESET) begin
      slot_cnt_r <= '0;
      idx_r      <= SEC_U;
    end else if (slot_last_s) begin
      slot_cnt_r <= '0;
      idx_r      <= idx_r + 2'd1;
    end else begin
      slot_cnt_r <= slot_cnt_r + CNT_W'(1);
    end
  end

  // Frame boundary: input snapshot, frame counter and blink phase
  always_ff @(posedge clk_in or posedge RESET) begin
    if (RESET) begin
      snap_r      <= '0;
      frame_cnt_r <= '0;
      phase_r     <= 1'b1;
    end else if (frame_wrap_s) begin
      snap_r <= '{time_bcd: bus.TIME_BCD, running: bus.RUNNING,
                  limit: bus.LIMIT, lzb: bus.LZB};
      if (frame_cnt_r == FRM_LAST) begin
        frame_cnt_r <= '0;
        phase_r     <= ~phase_r;
      end else begin
        frame_cnt_r <= frame_cnt_r + FRM_W'(1);
      end
    end
  end

  // Output registers, one cycle behind the scan state
  always_ff @(posedge clk_in or posedge RESET) begin
    if (RESET) begin
      an_r  <= 4'b1111;
      seg_r <= SEG_BLANK;
      dp_r  <= 1'b1;
    end else begin
      an_r  <= an_next_s;
      seg_r <= seg_s;
      dp_r  <= dp_next_s;
    end
  end

  assign bus.AN  = an_r;
  assign bus.SEG = seg_r;
  assign bus.DP  = dp_r;

endmodule

// File: tb/tb_stopwatch_display_scan.sv
// Scoreboard bench for stopwatch_display_scan with SCAN_DIV=4, GUARD=1, BLINK_FRAMES=2.
module tb_stopwatch_display_scan;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } obs_t;

  typedef struct packed {
    logic [15:0] tbcd;
    logic        running;
    logic        limit;
    logic        lzb;
    logic [3:0]  en;      // digits whose anode lights after the guard cycle
    logic [27:0] segs;    // {d3,d2,d1,d0} expected segment patterns
    logic        dp_low;  // colon lit during the min-units slot
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  bit   active = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   pos = 0;
  obs_t exp_q[$];
  vec_t vecs[0:14];

  always #5 clk = ~clk;

  stopwatch_display_scan_if bus ();

  stopwatch_display_scan #(
    .SCAN_DIV     (4),
    .GUARD        (1),
    .BLINK_FRAMES (2)
  ) dut (
    .clk_in (clk),
    .RESET  (rst),
    .bus    (bus)
  );

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_frame(input vec_t v);
    logic [3:0] an_on;
    logic [6:0] seg;
    logic       dp;
    for (int d = 0; d < 4; d++) begin
      an_on = ~(4'b0001 << d);
      seg   = v.segs[d*7 +: 7];
      dp    = (d == 2 && v.dp_low) ? 1'b0 : 1'b1;
      exp_q.push_back('{an: 4'b1111, seg: seg, dp: 1'b1});
      for (int k = 0; k < 3; k++) begin
        if (v.en[d]) exp_q.push_back('{an: an_on, seg: seg, dp: dp});
        else         exp_q.push_back('{an: 4'b1111, seg: seg, dp: 1'b1});
      end
    end
  endtask

  task automatic drive(input vec_t v);
    bus.TIME_BCD = v.tbcd;
    bus.RUNNING  = v.running;
    bus.LIMIT    = v.limit;
    bus.LZB      = v.lzb;
  endtask

  // Monitor: one expected observation per clock once scanning has restarted
  initial begin
    obs_t e;
    forever begin
      @(negedge clk);
      if (active && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("scan c=%0d", pos), {bus.AN, bus.SEG, bus.DP}, e);
        pos++;
      end
    end
  end

  initial begin
    vec_t f0;
    int   n;
    //            tbcd     run   lim   lzb   en       segs {d3,d2,d1,d0}                dp_low
    vecs[0]  = '{16'h4059, 1'b1, 1'b0, 1'b0, 4'b1111, {7'h19, 7'h40, 7'h12, 7'h10}, 1'b1};
    vecs[1]  = '{16'h1020, 1'b1, 1'b0, 1'b0, 4'b1111, {7'h79, 7'h40, 7'h24, 7'h40}, 1'b1};
    vecs[2]  = '{16'h4030, 1'b1, 1'b0, 1'b0, 4'b1111, {7'h19, 7'h40, 7'h30, 7'h40}, 1'b1};
    vecs[3]  = '{16'h0A35, 1'b1, 1'b0, 1'b1, 4'b0111, {7'h40, 7'h3F, 7'h30, 7'h12}, 1'b1};
    vecs[4]  = '{16'h1234, 1'b0, 1'b1, 1'b0, 4'b1111, {7'h79, 7'h24, 7'h30, 7'h19}, 1'b1};
    vecs[5]  = '{16'h1234, 1'b0, 1'b1, 1'b0, 4'b0000, {7'h79, 7'h24, 7'h30, 7'h19}, 1'b0};
    vecs[6]  = '{16'h1234, 1'b0, 1'b1, 1'b0, 4'b0000, {7'h79, 7'h24, 7'h30, 7'h19}, 1'b0};
    vecs[7]  = '{16'h1234, 1'b0, 1'b1, 1'b0, 4'b1111, {7'h79, 7'h24, 7'h30, 7'h19}, 1'b1};
    vecs[8]  = '{16'h5959, 1'b0, 1'b0, 1'b0, 4'b1111, {7'h12, 7'h10, 7'h12, 7'h10}, 1'b1};
    vecs[9]  = '{16'h5959, 1'b0, 1'b0, 1'b0, 4'b1111, {7'h12, 7'h10, 7'h12, 7'h10}, 1'b0};
    vecs[10] = '{16'h5959, 1'b0, 1'b0, 1'b0, 4'b1111, {7'h12, 7'h10, 7'h12, 7'h10}, 1'b0};
    vecs[11] = '{16'h5959, 1'b0, 1'b0, 1'b0, 4'b1111, {7'h12, 7'h10, 7'h12, 7'h10}, 1'b1};
    vecs[12] = '{16'h0000, 1'b1, 1'b0, 1'b1, 4'b0111, {7'h40, 7'h40, 7'h40, 7'h40}, 1'b1};
    vecs[13] = '{16'hCDEF, 1'b1, 1'b0, 1'b1, 4'b1111, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 1'b1};
    vecs[14] = '{16'h0000, 1'b1, 1'b1, 1'b1, 4'b0000, {7'h40, 7'h40, 7'h40, 7'h40}, 1'b0};
    f0       = '{16'h0000, 1'b0, 1'b0, 1'b0, 4'b1111, {7'h40, 7'h40, 7'h40, 7'h40}, 1'b1};

    rst = 1'b1;
    drive('{16'h1234, 1'b1, 1'b0, 1'b0, 4'b0000, 28'h0, 1'b0});
    repeat (3) @(negedge clk);
    check("reset AN", {8'h00, bus.AN}, 12'h00F);
    check("reset SEG", {5'h00, bus.SEG}, 12'h07F);
    check("reset DP", {11'h000, bus.DP}, 12'h001);

    // Run a few cycles, then hit reset mid-slot (scan at index 1, slot 2)
    rst = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    check("pre-reset AN", {8'h00, bus.AN}, 12'h00D);
    check("pre-reset SEG", {5'h00, bus.SEG}, 12'h040);
    rst = 1'b1;
    #1;
    check("async reset AN", {8'h00, bus.AN}, 12'h00F);
    check("async reset SEG", {5'h00, bus.SEG}, 12'h07F);
    check("async reset DP", {11'h000, bus.DP}, 12'h001);
    repeat (2) @(negedge clk);

    push_frame(f0);
    @(negedge clk);
    #1;
    rst    = 1'b0;
    active = 1'b1;
    drive(vecs[0]);
    push_frame(vecs[0]);

    // Each new vector lands during digit index 1 of the frame before it shows
    repeat (22) @(negedge clk);
    for (int i = 1; i < 15; i++) begin
      drive(vecs[i]);
      push_frame(vecs[i]);
      repeat (16) @(negedge clk);
    end

    n = 0;
    while (exp_q.size() > 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d observations left, expected 0", exp_q.size());
    end
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
